// File: rtl/uart_link_if.sv
// Bundle of the uart_link data, control and status signals.
// tx_state_dbg/rx_state_dbg expose the FSM encodings: 0 is IDLE for both.
`timescale 1ns/1ps
interface uart_link_if #(
  parameter int D_WIDTH = 8
);
  // transmit/busy: transmit is a level request; a word is accepted on any rising
  // edge with transmit=1 and busy=0, and busy stays high until the last stop bit
  // ends. valid_rx is a one-cycle strobe with no back-pressure.
  logic [D_WIDTH-1:0] TX_data;
  logic               transmit;
  logic               loopback;
  logic               RxD;
  logic               TxD;
  logic               busy;
  logic [D_WIDTH-1:0] Rx_Data;
  logic               valid_rx;
  logic               parity_error;
  logic               stop_error;
  logic [2:0]         tx_state_dbg;
  logic [2:0]         rx_state_dbg;

  modport master (
    output TX_data, transmit, loopback, RxD,
    input  TxD, busy, Rx_Data, valid_rx, parity_error, stop_error,
    input  tx_state_dbg, rx_state_dbg
  );

  modport slave (
    input  TX_data, transmit, loopback, RxD,
    output TxD, busy, Rx_Data, valid_rx, parity_error, stop_error,
    output tx_state_dbg, rx_state_dbg
  );
endinterface

// File: rtl/uart_link.sv
// Single-clock UART: shared oversample tick generator, TX and RX FSMs.
// Ticks are clock enables; RxD is synchronised, the loopback path is not.
`timescale 1ns/1ps
module uart_link #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int D_WIDTH    = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic        clk,
  input logic        rst,
  uart_link_if.slave bus
);
  localparam int RAW_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (RAW_DIV < 1) ? 1 : RAW_DIV;
  localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCW     = $clog2(STOP_BITS * OVERSAMPLE + 1);
  localparam int BW      = $clog2(D_WIDTH + 1);

  localparam logic [DCW-1:0] DIV_END  = DCW'(DIV - 1);
  localparam logic [TCW-1:0] BIT_END  = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] HALF_END = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] STOP_END = TCW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BW-1:0]  LAST_BIT = BW'(D_WIDTH - 1);
  localparam logic           PODD     = (PARITY_ODD != 0);
  localparam logic           PEN      = (PARITY_EN != 0);

  // ---------------- tick generator ----------------
  logic [DCW-1:0] div_cnt;
  logic           tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   div_cnt <= '0;
    else if (div_cnt == DIV_END) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_END);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  tx_state_t          tx_state, tx_state_d;
  logic [TCW-1:0]     tx_cnt, tx_cnt_d;
  logic [BW-1:0]      tx_bit, tx_bit_d;
  logic [D_WIDTH-1:0] tx_shift, tx_shift_d;
  logic               tx_par, tx_par_d;
  logic               txd_q, txd_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx_par   <= tx_par_d;
      txd_q    <= txd_d;
    end
  end

  // TxD is registered alongside the state so the line never glitches.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_par_d   = tx_par;
    txd_d      = txd_q;
    case (tx_state)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (bus.transmit) begin
          tx_state_d = TX_START;
          tx_shift_d = bus.TX_data;
          tx_par_d   = (^bus.TX_data) ^ PODD;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_cnt == BIT_END) begin
            tx_state_d = TX_DATA;
            tx_cnt_d   = '0;
            txd_d      = tx_shift[0];
          end else begin
            tx_cnt_d = tx_cnt + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_cnt == BIT_END) begin
            tx_cnt_d   = '0;
            tx_shift_d = tx_shift >> 1;
            if (tx_bit == LAST_BIT) begin
              tx_bit_d = '0;
              if (PEN) begin
                tx_state_d = TX_PARITY;
                txd_d      = tx_par;
              end else begin
                tx_state_d = TX_STOP;
                txd_d      = 1'b1;
              end
            end else begin
              tx_bit_d = tx_bit + 1'b1;
              txd_d    = tx_shift[1];
            end
          end else begin
            tx_cnt_d = tx_cnt + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          if (tx_cnt == BIT_END) begin
            tx_state_d = TX_STOP;
            tx_cnt_d   = '0;
            txd_d      = 1'b1;
          end else begin
            tx_cnt_d = tx_cnt + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_cnt == STOP_END) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d   = '0;
            txd_d      = 1'b1;
          end else begin
            tx_cnt_d = tx_cnt + 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  logic               rxd_s1, rxd_s2, rx_line;
  rx_state_t          rx_state, rx_state_d;
  logic [TCW-1:0]     rx_cnt, rx_cnt_d;
  logic [BW-1:0]      rx_bit, rx_bit_d;
  logic [D_WIDTH-1:0] rx_shift, rx_shift_d;
  logic               rx_par, rx_par_d;
  logic [D_WIDTH-1:0] rx_data_q, rx_data_d;
  logic               perr_q, perr_d;
  logic               serr_q, serr_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= bus.RxD;
      rxd_s2 <= rxd_s1;
    end
  end

  assign rx_line = bus.loopback ? txd_q : rxd_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      rx_data_q <= '0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      rx_state  <= rx_state_d;
      rx_cnt    <= rx_cnt_d;
      rx_bit    <= rx_bit_d;
      rx_shift  <= rx_shift_d;
      rx_par    <= rx_par_d;
      rx_data_q <= rx_data_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      valid_q   <= valid_d;
    end
  end

  // Samples fall at bit centres: half a bit after the first low tick, then every bit.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_par_d   = rx_par;
    rx_data_d  = rx_data_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    valid_d    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (tick && !rx_line) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_cnt == HALF_END) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_cnt == BIT_END) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_line, rx_shift[D_WIDTH-1:1]};
            if (rx_bit == LAST_BIT) begin
              rx_bit_d   = '0;
              rx_state_d = PEN ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_d = rx_bit + 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          if (rx_cnt == BIT_END) begin
            rx_cnt_d   = '0;
            rx_par_d   = rx_line;
            rx_state_d = RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_cnt == BIT_END) begin
            rx_cnt_d   = '0;
            rx_data_d  = rx_shift;
            perr_d     = PEN ? (rx_par ^ (^rx_shift) ^ PODD) : 1'b0;
            serr_d     = ~rx_line;
            valid_d    = 1'b1;
            rx_state_d = rx_line ? RX_IDLE : RX_BREAK;
          end else begin
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      RX_BREAK: begin
        if (tick && rx_line) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign bus.TxD          = txd_q;
  assign bus.busy         = (tx_state != TX_IDLE);
  assign bus.Rx_Data      = rx_data_q;
  assign bus.valid_rx     = valid_q;
  assign bus.parity_error = perr_q;
  assign bus.stop_error   = serr_q;
  assign bus.tx_state_dbg = tx_state;
  assign bus.rx_state_dbg = rx_state;
endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link: 8E1 loopback, 8O1 external RxD and 9N2 back-to-back
// instances on one clock; received frames are checked against an expected queue.
`timescale 1ns/1ps
module tb_uart_link;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT      = 160;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // expected frame = {parity_error, stop_error, 9-bit data}
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];

  uart_link_if #(.D_WIDTH(8)) if0 ();
  uart_link_if #(.D_WIDTH(8)) if1 ();
  uart_link_if #(.D_WIDTH(9)) if2 ();

  uart_link #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .D_WIDTH(8),
              .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst(rst), .bus(if0));
  uart_link #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .D_WIDTH(8),
              .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst(rst), .bus(if1));
  uart_link #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .D_WIDTH(9),
              .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_9n2 (.clk(clk), .rst(rst), .bus(if2));

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_pop(input int ch, input logic [10:0] obs);
    logic [10:0] exp;
    int sz;
    sz = (ch == 0) ? exp_q0.size() : (ch == 1) ? exp_q1.size() : exp_q2.size();
    n_assert++;
    assert (sz > 0) else begin
      n_fail++;
      $error("FAIL rx%0d_spurious: valid_rx with frame 0x%0h, expected no frame", ch, obs);
    end
    if (sz > 0) begin
      case (ch)
        0:       exp = exp_q0.pop_front();
        1:       exp = exp_q1.pop_front();
        default: exp = exp_q2.pop_front();
      endcase
      check($sformatf("rx%0d_frame", ch), 32'(obs), 32'(exp));
    end
  endtask

  // Scoreboard side: every valid_rx pops one expected frame.
  always @(negedge clk) begin
    if (rst && if0.valid_rx) rx_pop(0, {if0.parity_error, if0.stop_error, 1'b0, if0.Rx_Data});
    if (rst && if1.valid_rx) rx_pop(1, {if1.parity_error, if1.stop_error, 1'b0, if1.Rx_Data});
    if (rst && if2.valid_rx) rx_pop(2, {if2.parity_error, if2.stop_error, if2.Rx_Data});
  end

  function automatic logic [10:0] exp_frame_odd(input logic [7:0] data, input logic par,
                                                input logic stopv);
    logic good_par;
    good_par = ~(^data);
    return {(par != good_par), ~stopv, 1'b0, data};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 32'd0);
  endtask

  // Sends one word on the 8E1 loopback instance and checks every bit centre on TxD.
  task automatic send_check_8e1(input logic [7:0] data);
    logic [10:0] bits;
    int m;
    int total;
    bits = {1'b1, ^data, data, 1'b0};
    @(negedge clk);
    if0.TX_data  = data;
    if0.transmit = 1'b1;
    @(posedge clk);
    #1;
    if0.transmit = 1'b0;
    check("tx_accept_busy", 32'(if0.busy), 32'd1);
    check("tx_accept_txd", 32'(if0.TxD), 32'd0);
    exp_q0.push_back({2'b00, 1'b0, data});
    repeat (BIT / 2) @(posedge clk);
    #1;
    for (int k = 0; k < 11; k++) begin
      check($sformatf("tx_bit%0d", k), 32'(if0.TxD), 32'(bits[k]));
      if (k < 10) begin
        repeat (BIT) @(posedge clk);
        #1;
      end
    end
    check("tx_busy_in_stop", 32'(if0.busy), 32'd1);
    m = 0;
    while (if0.busy && m < 200) begin
      @(posedge clk);
      #1;
      m++;
    end
    total = BIT / 2 + 10 * BIT + m;
    n_assert++;
    assert ((total >= 11 * BIT - 10) && (total <= 11 * BIT)) else begin
      n_fail++;
      $error("FAIL tx_busy_len: observed %0d clks expected %0d..%0d", total, 11 * BIT - 10, 11 * BIT);
    end
  endtask

  // Drives one 8O1 frame onto the external RxD of the second instance.
  task automatic rx_send(input logic [7:0] data, input logic par, input logic stopv);
    logic [10:0] bits;
    bits = {stopv, par, data, 1'b0};
    exp_q1.push_back(exp_frame_odd(data, par, stopv));
    for (int k = 0; k < 11; k++) begin
      if1.RxD = bits[k];
      repeat (BIT) @(negedge clk);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    if0.TX_data = '0; if0.transmit = 1'b0; if0.loopback = 1'b1; if0.RxD = 1'b1;
    if1.TX_data = '0; if1.transmit = 1'b0; if1.loopback = 1'b0; if1.RxD = 1'b1;
    if2.TX_data = '0; if2.transmit = 1'b0; if2.loopback = 1'b1; if2.RxD = 1'b1;

    #2 rst = 1'b0;
    #21;
    check("rst_txd", 32'(if0.TxD), 32'd1);
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_rx_data", 32'(if0.Rx_Data), 32'd0);
    check("rst_valid", 32'(if0.valid_rx), 32'd0);
    check("rst_perr", 32'(if1.parity_error), 32'd0);
    check("rst_serr", 32'(if1.stop_error), 32'd0);
    check("rst_txd_9n2", 32'(if2.TxD), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // 8E1 loopback, 0xA5
    send_check_8e1(8'hA5);
    drain("t1");

    // 8O1 external: bad parity, then a good frame clears the flag
    rx_send(8'h3C, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check("t2_perr_hold", 32'(if1.parity_error), 32'd1);
    rx_send(8'h00, 1'b1, 1'b1);
    repeat (BIT) @(negedge clk);
    check("t2_perr_clear", 32'(if1.parity_error), 32'd0);
    drain("t2");

    // stop bit low, line held low for three more bits, then a good frame
    rx_send(8'h55, 1'b1, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    check("t3_serr_hold", 32'(if1.stop_error), 32'd1);
    if1.RxD = 1'b1;
    repeat (BIT) @(negedge clk);
    rx_send(8'h81, 1'b1, 1'b1);
    repeat (BIT / 2) @(negedge clk);
    check("t3_serr_clear", 32'(if1.stop_error), 32'd0);
    drain("t3");

    // 40-clk low glitch is rejected as a false start
    if1.RxD = 1'b0;
    repeat (40) @(negedge clk);
    if1.RxD = 1'b1;
    repeat (120) @(negedge clk);
    check("t4_rx_idle", 32'(if1.rx_state_dbg), 32'd0);
    rx_send(8'hFF, 1'b1, 1'b1);
    repeat (BIT / 2) @(negedge clk);
    drain("t4");

    // 9N2 loopback with transmit held high: back-to-back frames
    @(negedge clk);
    if2.TX_data  = 9'h1AB;
    if2.transmit = 1'b1;
    n = 0;
    while (!if2.busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_accept", 32'(if2.busy), 32'd1);
    for (int f = 0; f < 3; f++) begin
      exp_q2.push_back({2'b00, 9'h1AB});
      if (f == 2) if2.transmit = 1'b0;
      n = 0;
      while (if2.busy && n < 2500) begin
        @(negedge clk);
        n++;
      end
      n_assert++;
      assert ((n >= 12 * BIT - 10) && (n <= 12 * BIT)) else begin
        n_fail++;
        $error("FAIL t5_len%0d: observed %0d clks expected %0d..%0d", f, n, 12 * BIT - 10, 12 * BIT);
      end
      @(negedge clk);
      if (f < 2) begin
        check($sformatf("t5_gap%0d_busy", f), 32'(if2.busy), 32'd1);
        check($sformatf("t5_gap%0d_txd", f), 32'(if2.TxD), 32'd0);
      end else begin
        check("t5_stop_busy", 32'(if2.busy), 32'd0);
      end
    end
    drain("t5");

    // asynchronous reset in the middle of a DATA bit
    @(negedge clk);
    if0.TX_data  = 8'hC3;
    if0.transmit = 1'b1;
    @(negedge clk);
    if0.transmit = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check("t6_busy_before", 32'(if0.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_txd", 32'(if0.TxD), 32'd1);
    check("t6_rst_busy", 32'(if0.busy), 32'd0);
    check("t6_rst_rx_data", 32'(if0.Rx_Data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_check_8e1(8'h5A);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
